// File: rtl/fft_frame_arbiter.sv
// Shares one streaming FFT core between two sample requesters, one whole frame at a time,
// and tags returned frames with their owner. Define FFT_ARB_CFG_CACHE_EN to skip repeated configs.
module fft_frame_arbiter #(
   parameter int FFT_LEN     = 256,
   parameter int CFG_LATENCY = 4,
   parameter bit FWD_INV0    = 1'b1,
   parameter bit FWD_INV1    = 1'b0
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] s0_axis_tdata,
   input  logic        s0_axis_tvalid,
   input  logic        s0_axis_tlast,
   output logic        s0_axis_tready,
   input  logic [31:0] s1_axis_tdata,
   input  logic        s1_axis_tvalid,
   input  logic        s1_axis_tlast,
   output logic        s1_axis_tready,
   output logic [23:0] m_axis_cfg_tdata,
   output logic        m_axis_cfg_tvalid,
   input  logic        m_axis_cfg_tready,
   output logic [31:0] m_axis_fft_tdata,
   output logic        m_axis_fft_tvalid,
   output logic        m_axis_fft_tlast,
   input  logic        m_axis_fft_tready,
   input  logic [31:0] s_axis_res_tdata,
   input  logic        s_axis_res_tvalid,
   input  logic        s_axis_res_tlast,
   output logic        s_axis_res_tready,
   output logic [31:0] m_axis_res_tdata,
   output logic        m_axis_res_tvalid,
   output logic        m_axis_res_tlast,
   output logic        m_axis_res_tid,
   input  logic        m_axis_res_tready,
   output logic        frame_trunc,
   output logic        res_orphan
);
   // state    | meaning
   // IDLE     | no frame in progress; arbitrate when the owner FIFO has room
   // CONFIG   | config word presented to the core, waiting for its handshake
   // CFG_WAIT | settle delay between config and the first data beat
   // XFER     | owner samples passed straight through to the core
   // PAD      | zero beats fill the frame up to FFT_LEN

   localparam int LOG2_LEN = $clog2(FFT_LEN);
   localparam int CNT_W    = LOG2_LEN + 1;
   localparam int WAIT_W   = (CFG_LATENCY < 2) ? 1 : $clog2(CFG_LATENCY + 1);

   typedef enum logic [2:0] {IDLE, CONFIG, CFG_WAIT, XFER, PAD} state_t;

   state_t            state, state_nxt;
   logic              owner;
   logic              last_grant;
   logic [CNT_W-1:0]  beat_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        fifo_mem;
   logic              fifo_wr;
   logic              fifo_rd;
   logic [1:0]        fifo_cnt;

   logic        grant;
   logic        grant_sel;
   logic        cache_hit;
   logic        fifo_empty;
   logic        fifo_full;
   logic        fft_hs;
   logic        cfg_hs;
   logic        res_hs;
   logic        res_pop;
   logic        owner_tlast;
   logic [23:0] word_owner;

   function automatic logic [23:0] cfg_word(input logic sel);
      logic [23:0] w;
      w      = '0;
      w[4:0] = 5'(LOG2_LEN);
      w[8]   = sel ? FWD_INV1 : FWD_INV0;
      return w;
   endfunction

   assign fifo_empty  = (fifo_cnt == 2'd0);
   assign fifo_full   = (fifo_cnt == 2'd2);
   assign grant_sel   = (s0_axis_tvalid && s1_axis_tvalid) ? ~last_grant : s1_axis_tvalid;
   assign grant       = (state == IDLE) && (s0_axis_tvalid || s1_axis_tvalid) && !fifo_full;
   assign word_owner  = cfg_word(owner);
   assign owner_tlast = owner ? s1_axis_tlast : s0_axis_tlast;
   assign fft_hs      = m_axis_fft_tvalid && m_axis_fft_tready;
   assign cfg_hs      = m_axis_cfg_tvalid && m_axis_cfg_tready;

`ifdef FFT_ARB_CFG_CACHE_EN
   logic [23:0] cache_word;
   logic        cache_vld;
   logic [23:0] word_sel;

   assign word_sel  = cfg_word(grant_sel);
   assign cache_hit = cache_vld && (cache_word == word_sel);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cache_word <= '0;
         cache_vld  <= 1'b0;
      end else if (cfg_hs) begin
         cache_word <= word_owner;
         cache_vld  <= 1'b1;
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   always_comb begin
      state_nxt         = state;
      s0_axis_tready    = 1'b0;
      s1_axis_tready    = 1'b0;
      m_axis_cfg_tvalid = 1'b0;
      m_axis_cfg_tdata  = '0;
      m_axis_fft_tdata  = '0;
      m_axis_fft_tvalid = 1'b0;
      m_axis_fft_tlast  = 1'b0;
      frame_trunc       = 1'b0;
      case (state)
         IDLE: begin
            if (grant) state_nxt = cache_hit ? XFER : CONFIG;
         end
         CONFIG: begin
            m_axis_cfg_tvalid = 1'b1;
            m_axis_cfg_tdata  = word_owner;
            if (m_axis_cfg_tready) state_nxt = (CFG_LATENCY == 0) ? XFER : CFG_WAIT;
         end
         CFG_WAIT: begin
            if (wait_cnt == WAIT_W'(1)) state_nxt = XFER;
         end
         XFER: begin
            m_axis_fft_tdata  = owner ? s1_axis_tdata : s0_axis_tdata;
            m_axis_fft_tvalid = owner ? s1_axis_tvalid : s0_axis_tvalid;
            m_axis_fft_tlast  = (beat_cnt == CNT_W'(1));
            if (owner) s1_axis_tready = m_axis_fft_tready;
            else       s0_axis_tready = m_axis_fft_tready;
            if (fft_hs) begin
               // A frame that runs to FFT_LEN without tlast is cut; the rest waits for a new grant
               if (beat_cnt == CNT_W'(1)) begin
                  state_nxt   = IDLE;
                  frame_trunc = !owner_tlast;
               end else if (owner_tlast) begin
                  state_nxt = PAD;
               end
            end
         end
         PAD: begin
            m_axis_fft_tvalid = 1'b1;
            m_axis_fft_tlast  = (beat_cnt == CNT_W'(1));
            if (fft_hs && beat_cnt == CNT_W'(1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         beat_cnt   <= '0;
         wait_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            beat_cnt   <= CNT_W'(FFT_LEN);
         end else if (fft_hs) begin
            beat_cnt <= beat_cnt - CNT_W'(1);
         end
         if (cfg_hs)                 wait_cnt <= WAIT_W'(CFG_LATENCY);
         else if (state == CFG_WAIT) wait_cnt <= wait_cnt - WAIT_W'(1);
      end
   end

   // Owner FIFO: one entry per frame handed to the core, retired on the result tlast
   assign res_hs            = s_axis_res_tvalid && m_axis_res_tready;
   assign res_pop           = res_hs && s_axis_res_tlast && !fifo_empty;
   assign res_orphan        = res_hs && fifo_empty;
   assign m_axis_res_tdata  = s_axis_res_tdata;
   assign m_axis_res_tvalid = s_axis_res_tvalid;
   assign m_axis_res_tlast  = s_axis_res_tlast;
   assign s_axis_res_tready = m_axis_res_tready;
   assign m_axis_res_tid    = fifo_empty ? 1'b0 : fifo_mem[fifo_rd];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         fifo_mem <= '0;
         fifo_wr  <= 1'b0;
         fifo_rd  <= 1'b0;
         fifo_cnt <= '0;
      end else begin
         if (grant) begin
            fifo_mem[fifo_wr] <= grant_sel;
            fifo_wr           <= ~fifo_wr;
         end
         if (res_pop) fifo_rd <= ~fifo_rd;
         case ({grant, res_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

endmodule
